// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between fetch (IF) and data (DM) requesters.
// Define MEM_ARB_ALIGN_CHK_EN to abort odd-address accesses without touching memory.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   output logic              dm_valid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              err
);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ABORT} state_t;
   state_t state;
   logic owner;
   logic [TW-1:0] timer;
   logic done, expire, fin;
   logic [ADDR_W-1:0] grant_addr;
   assign grant_addr = dm_req ? dm_addr : if_addr;
   assign done = (state == WAIT) && mem_done;
   assign expire = (state == WAIT) && !mem_done && (timer == TW'(TIMEOUT - 1));
   assign fin = done || expire || (state == ABORT);
   assign err = expire || (state == ABORT);
   assign if_valid = fin && !owner;
   assign dm_valid = fin && owner;
   assign if_rdata = (if_valid && done) ? mem_rdata : '0;
   assign dm_rdata = (dm_valid && done && !mem_wr) ? mem_rdata : '0;
   assign if_stall = if_req && !if_valid;
   assign dm_stall = dm_req && !dm_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         timer     <= '0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_req <= 1'b0;
         case (state)
            IDLE: if (dm_req || if_req) begin
               owner     <= dm_req;
               mem_addr  <= grant_addr;
               mem_wr    <= dm_req && dm_wr;
               mem_wdata <= dm_req ? dm_wdata : '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
               state     <= grant_addr[0] ? ABORT : ISSUE;
               mem_req   <= !grant_addr[0];
`else
               state     <= ISSUE;
               mem_req   <= 1'b1;
`endif
            end
            ISSUE: begin
               state <= WAIT;
               timer <= '0;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               state <= fin ? IDLE : WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int TO = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, mem_done = 1'b0;
   logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
   logic mem_req, mem_wr, if_valid, if_stall, dm_valid, dm_stall, err;
   logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
   int n_cmp = 0, n_bad = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .dm_req(dm_req), .dm_wr(dm_wr),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall), .dm_valid(dm_valid),
      .dm_rdata(dm_rdata), .dm_stall(dm_stall), .err(err));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #2;
      n_cmp++; if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_req_wr: got %b%b want 00", mem_req, mem_wr); end
      n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rst_addr_wdata: got %h %h want 0000 0000", mem_addr, mem_wdata); end
      n_cmp++; if ({if_valid, dm_valid, err} !== 3'b000) begin n_bad++; $display("FAIL rst_valid_err: got %b want 000", {if_valid, dm_valid, err}); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_if_fetch();
      tick(); if_req = 1'b1; if_addr = 16'h0002; #2;
      n_cmp++; if (if_stall !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_c0: got stall=%b req=%b want 1 0", if_stall, mem_req); end
      tick(); #2;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL fetch_issue: got req=%b addr=%h wr=%b want 1 0002 0", mem_req, mem_addr, mem_wr); end
      n_cmp++; if (if_stall !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_c1_stall: got stall=%b valid=%b want 1 0", if_stall, if_valid); end
      tick(); mem_done = 1'b1; mem_rdata = 16'hA5A5; #2;
      n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 16'hA5A5 || err !== 1'b0) begin n_bad++; $display("FAIL fetch_done: got valid=%b rdata=%h err=%b want 1 a5a5 0", if_valid, if_rdata, err); end
      n_cmp++; if (if_stall !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_c2: got stall=%b req=%b want 0 0", if_stall, mem_req); end
      tick(); mem_done = 1'b0; if_req = 1'b0; #2;
      n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse: got valid=%b want 0", if_valid); end
   endtask

   task automatic test_priority();
      tick(); dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'h1234; if_req = 1'b1; if_addr = 16'h0004; #2;
      tick(); #2;
      n_cmp++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0010) begin n_bad++; $display("FAIL prio_dm_issue: got req=%b wr=%b wdata=%h addr=%h want 1 1 1234 0010", mem_req, mem_wr, mem_wdata, mem_addr); end
      tick(); mem_done = 1'b1; mem_rdata = 16'hFFFF; #2;
      n_cmp++; if (dm_valid !== 1'b1 || dm_rdata !== 16'h0 || if_valid !== 1'b0 || if_stall !== 1'b1) begin n_bad++; $display("FAIL prio_dm_done: got dv=%b drd=%h iv=%b is=%b want 1 0000 0 1", dm_valid, dm_rdata, if_valid, if_stall); end
      tick(); mem_done = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; #2;
      n_cmp++; if (mem_req !== 1'b0 || if_stall !== 1'b1) begin n_bad++; $display("FAIL prio_idle: got req=%b is=%b want 0 1", mem_req, if_stall); end
      tick(); #2;
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004 || mem_wr !== 1'b0) begin n_bad++; $display("FAIL prio_if_issue: got req=%b addr=%h wr=%b want 1 0004 0", mem_req, mem_addr, mem_wr); end
      tick(); mem_done = 1'b1; mem_rdata = 16'h5A5A; #2;
      n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 16'h5A5A) begin n_bad++; $display("FAIL prio_if_done: got valid=%b rdata=%h want 1 5a5a", if_valid, if_rdata); end
      tick(); mem_done = 1'b0; if_req = 1'b0;
   endtask

   task automatic test_delayed_load();
      int stalls = 0;
      tick(); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) tick();
         mem_done = (i == 6); mem_rdata = 16'hBEEF; #2;
         stalls += int'(dm_stall);
         if (i == 1) begin n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin n_bad++; $display("FAIL load_issue: got req=%b addr=%h want 1 0020", mem_req, mem_addr); end end
      end
      n_cmp++; if (dm_valid !== 1'b1 || dm_rdata !== 16'hBEEF || err !== 1'b0) begin n_bad++; $display("FAIL load_done: got valid=%b rdata=%h err=%b want 1 beef 0", dm_valid, dm_rdata, err); end
      n_cmp++; if (stalls != 6) begin n_bad++; $display("FAIL load_stall_cycles: got %0d want 6", stalls); end
      tick(); mem_done = 1'b0; dm_req = 1'b0;
   endtask

   task automatic test_timeout();
      logic early = 1'b0;
      tick(); if_req = 1'b1; if_addr = 16'h0006;
      for (int i = 0; i <= TO + 1; i++) begin
         if (i > 0) tick();
         #2;
         if (i < TO + 1) early |= if_valid | dm_valid | err;
      end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", early); end
      n_cmp++; if (if_valid !== 1'b1 || err !== 1'b1 || if_rdata !== 16'h0) begin n_bad++; $display("FAIL to_abort: got valid=%b err=%b rdata=%h want 1 1 0000", if_valid, err, if_rdata); end
      tick(); if_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'h7777; #2;
      n_cmp++; if (if_valid !== 1'b0 || err !== 1'b0 || dm_valid !== 1'b0) begin n_bad++; $display("FAIL to_late_done: got iv=%b err=%b dv=%b want 0 0 0", if_valid, err, dm_valid); end
      tick(); mem_done = 1'b0; #2;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL to_idle: got req=%b want 0", mem_req); end
   endtask

   task automatic test_reset_mid();
      tick(); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
      tick();
      tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0; dm_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'h1111; #2;
      n_cmp++; if (dm_valid !== 1'b0 || if_valid !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_stray: got dv=%b iv=%b err=%b req=%b want 0 0 0 0", dm_valid, if_valid, err, mem_req); end
      n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL rstmid_addr: got %h want 0000", mem_addr); end
      tick(); mem_done = 1'b0; #2;
      n_cmp++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got req=%b dv=%b want 0 0", mem_req, dm_valid); end
   endtask

   task automatic test_align();
      tick(); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0011; #2;
      tick(); #2;
`ifdef MEM_ARB_ALIGN_CHK_EN
      n_cmp++; if (dm_valid !== 1'b1 || err !== 1'b1 || dm_rdata !== 16'h0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL align_abort: got dv=%b err=%b rd=%h req=%b want 1 1 0000 0", dm_valid, err, dm_rdata, mem_req); end
      tick(); dm_req = 1'b0; #2;
      n_cmp++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin n_bad++; $display("FAIL align_idle: got req=%b dv=%b want 0 0", mem_req, dm_valid); end
`else
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0011) begin n_bad++; $display("FAIL odd_issue: got req=%b addr=%h want 1 0011", mem_req, mem_addr); end
      tick(); mem_done = 1'b1; mem_rdata = 16'h0C0C; #2;
      n_cmp++; if (dm_valid !== 1'b1 || dm_rdata !== 16'h0C0C || err !== 1'b0) begin n_bad++; $display("FAIL odd_done: got dv=%b rd=%h err=%b want 1 0c0c 0", dm_valid, dm_rdata, err); end
      tick(); mem_done = 1'b0; dm_req = 1'b0;
`endif
   endtask

   // Transaction model: a grant at cycle g pulses mem_req at g+1 and completes at g+1+min(d,TO).
   task automatic test_random();
      int free_at = 0, req_c = -1, done_c = -1, due_if = 0, due_dm = 1, d;
      logic busy_if = 1'b0, busy_dm = 1'b0, own_dm = 1'b0, exp_err = 1'b0, exp_wr = 1'b0, eiv, edv;
      logic [15:0] exp_addr = '0, exp_wdata = '0, rd_val = '0, exp_rd = '0;
      for (int t = 0; t < 600; t++) begin
         tick();
         if (!busy_if && t >= due_if) begin busy_if = 1'b1; if_addr = 16'($urandom) & 16'hFFFE; end
         if (!busy_dm && t >= due_dm) begin busy_dm = 1'b1; dm_addr = 16'($urandom) & 16'hFFFE; dm_wr = 1'($urandom_range(0, 1)); dm_wdata = 16'($urandom); end
         if_req = busy_if; dm_req = busy_dm;
         if (t >= free_at && (busy_if || busy_dm)) begin
            own_dm = busy_dm; exp_addr = busy_dm ? dm_addr : if_addr; exp_wr = busy_dm && dm_wr; exp_wdata = dm_wdata;
            d = $urandom_range(1, TO + 2);
            exp_err = d > TO; req_c = t + 1; done_c = t + 1 + (exp_err ? TO : d); free_at = done_c + 1;
            rd_val = 16'($urandom); exp_rd = (exp_err || exp_wr) ? 16'h0 : rd_val;
         end
         if (t == done_c) begin mem_done = !exp_err; mem_rdata = rd_val; end
         else begin mem_done = (t <= req_c || t > done_c) && ($urandom_range(0, 3) == 0); mem_rdata = 16'($urandom); end
         #2;
         eiv = (t == done_c) && !own_dm; edv = (t == done_c) && own_dm;
         n_cmp++; if (mem_req !== (t == req_c)) begin n_bad++; $display("FAIL rnd_req t=%0d: got %b want %b", t, mem_req, t == req_c); end
         if (t == req_c) begin n_cmp++; if (mem_addr !== exp_addr || mem_wr !== exp_wr) begin n_bad++; $display("FAIL rnd_addr t=%0d: got %h/%b want %h/%b", t, mem_addr, mem_wr, exp_addr, exp_wr); end end
         if (t == req_c && own_dm) begin n_cmp++; if (mem_wdata !== exp_wdata) begin n_bad++; $display("FAIL rnd_wdata t=%0d: got %h want %h", t, mem_wdata, exp_wdata); end end
         n_cmp++; if (if_valid !== eiv || dm_valid !== edv || err !== ((t == done_c) && exp_err)) begin n_bad++; $display("FAIL rnd_valid t=%0d: got %b%b%b want %b%b%b", t, if_valid, dm_valid, err, eiv, edv, (t == done_c) && exp_err); end
         if (eiv) begin n_cmp++; if (if_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_if_rdata t=%0d: got %h want %h", t, if_rdata, exp_rd); end end
         if (edv) begin n_cmp++; if (dm_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_dm_rdata t=%0d: got %h want %h", t, dm_rdata, exp_rd); end end
         n_cmp++; if (if_stall !== (busy_if && !eiv) || dm_stall !== (busy_dm && !edv)) begin n_bad++; $display("FAIL rnd_stall t=%0d: got %b%b want %b%b", t, if_stall, dm_stall, busy_if && !eiv, busy_dm && !edv); end
         if (eiv) begin busy_if = 1'b0; due_if = t + 1 + $urandom_range(0, 2); end
         if (edv) begin busy_dm = 1'b0; due_dm = t + 1 + $urandom_range(0, 3); end
      end
      tick(); if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_if_fetch();
      test_priority();
      test_delayed_load();
      test_timeout();
      test_reset_mid();
      test_align();
      test_random();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
